// File: rtl/rifl_err_inj_pkg.sv
// rifl_err_inj_pkg: shared state and mode encodings for the error-injection controller.
package rifl_err_inj_pkg;
  typedef enum logic [1:0] {IDLE, INJECT, GAP} state_e;
  typedef enum logic [1:0] {CONT, BURST, SINGLE, RSVD} mode_e;
endpackage

// File: rtl/rifl_popcount.sv
// rifl_popcount: combinational population count of a DWIDTH-bit vector.
module rifl_popcount #(
  parameter int DWIDTH = 64,
  parameter int OW = $clog2(DWIDTH + 1)
) (
  input  logic [DWIDTH-1:0] in_i,
  output logic [OW-1:0]     cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < DWIDTH; i++) cnt_o = cnt_o + OW'(in_i[i]);
  end
endmodule

// File: rtl/rifl_err_inj_ctrl.sv
// rifl_err_inj_ctrl: campaign FSM and registered XOR datapath for link error injection.
// Define RIFL_ERR_INJ_BITCNT_EN to add the bit_err_cnt popcount statistic.
module rifl_err_inj_ctrl
  import rifl_err_inj_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic [63:0]       cfg_threshold,
  input  logic [15:0]       cfg_burst_len,
  input  logic [15:0]       cfg_gap_len,
  input  logic              start,
  input  logic              stop,
  input  logic              cnt_clr,
  output logic              busy,
  output logic [63:0]       threshold,
  input  logic [DWIDTH-1:0] err_vec,
  input  logic [DWIDTH-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DWIDTH-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
`ifdef RIFL_ERR_INJ_BITCNT_EN
  output logic [CNT_W-1:0]  beat_err_cnt,
  output logic [CNT_W-1:0]  bit_err_cnt
`else
  output logic [CNT_W-1:0]  beat_err_cnt
`endif
);
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [63:0] thr_q, thr_d, threshold_q;
  logic [15:0] blen_q, blen_d, glen_q, glen_d, win_q, win_d, win_inc, blen_eff;
  logic [DWIDTH-1:0] mask, m_tdata_q;
  logic m_tvalid_q, acc;
  logic [CNT_W-1:0] beat_cnt_q;
  assign s_tready = !m_tvalid_q | m_tready;
  assign acc = s_tvalid & s_tready;
  assign mask = state_q == INJECT ? err_vec : '0;
  assign busy = state_q != IDLE;
  assign blen_eff = blen_q == 16'd0 ? 16'd1 : blen_q;
  assign win_inc = win_q + 16'd1;
  assign threshold = threshold_q;
  assign m_tdata = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign beat_err_cnt = beat_cnt_q;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    thr_d = thr_q;
    blen_d = blen_q;
    glen_d = glen_q;
    win_d = win_q;
    if (stop) begin
      state_d = IDLE;
      win_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start && mode_e'(cfg_mode) != RSVD) begin
          state_d = INJECT;
          mode_d = mode_e'(cfg_mode);
          thr_d = cfg_threshold;
          blen_d = cfg_burst_len;
          glen_d = cfg_gap_len;
          win_d = '0;
        end
        // CONT never ends a window, so its counter stays parked at zero
        INJECT: if (acc && mode_q != CONT) begin
          win_d = win_inc == blen_eff ? '0 : win_inc;
          if (win_inc == blen_eff)
            state_d = mode_q == SINGLE ? IDLE : (glen_q == 16'd0 ? INJECT : GAP);
        end
        GAP: if (acc) begin
          win_d = win_inc == glen_q ? '0 : win_inc;
          state_d = win_inc == glen_q ? INJECT : GAP;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= CONT;
      thr_q <= '0;
      blen_q <= '0;
      glen_q <= '0;
      win_q <= '0;
      threshold_q <= '0;
      m_tdata_q <= '0;
      m_tvalid_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      thr_q <= thr_d;
      blen_q <= blen_d;
      glen_q <= glen_d;
      win_q <= win_d;
      threshold_q <= state_d != IDLE ? thr_d : '0;
      if (acc) m_tdata_q <= s_tdata ^ mask;
      m_tvalid_q <= acc | (m_tvalid_q & !m_tready);
      if (cnt_clr) beat_cnt_q <= '0;
      else if (acc && |mask && !(&beat_cnt_q)) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
    end
  end
`ifdef RIFL_ERR_INJ_BITCNT_EN
  localparam int PW = $clog2(DWIDTH + 1);
  logic [PW-1:0] pc;
  logic [CNT_W:0] bit_sum;
  logic [CNT_W-1:0] bit_cnt_q;
  rifl_popcount #(.DWIDTH(DWIDTH)) u_popcount (.in_i(mask), .cnt_o(pc));
  assign bit_sum = {1'b0, bit_cnt_q} + (CNT_W + 1)'(pc);
  assign bit_err_cnt = bit_cnt_q;
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) bit_cnt_q <= '0;
    else if (acc) bit_cnt_q <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
  end
`endif
endmodule

// File: doc/rifl_err_inj_ctrl.md
RIFL_ERR_INJ_CTRL -- requirements
Module: rifl_err_inj_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 64: data and error-vector width.
REQ-002 SHALL have parameter CNT_W, default 32: width of statistics counters.
REQ-003 SHALL have port clk  input  1: sole clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port cfg_mode  input  2: 0 CONT, 1 BURST, 2 SINGLE, 3 reserved.
REQ-006 SHALL have port cfg_threshold  input  64: BER threshold forwarded to the injector.
REQ-007 SHALL have port cfg_burst_len  input  16: corrupted-window length in accepted beats.
REQ-008 SHALL have port cfg_gap_len  input  16: clean-window length in accepted beats (BURST only).
REQ-009 SHALL have port start  input  1: single-cycle pulse that begins a campaign.
REQ-010 SHALL have port stop  input  1: single-cycle pulse that aborts a campaign.
REQ-011 SHALL have port cnt_clr  input  1: clears the statistics counters.
REQ-012 SHALL have port busy  output  1: high when state is not IDLE.
REQ-013 SHALL have port threshold  output  64: drives the injector threshold input.
REQ-014 SHALL have port err_vec  input  DWIDTH: per-bit error vector from the injector.
REQ-015 SHALL have ports s_tdata/s_tvalid/s_tready  in/in/out  DWIDTH/1/1: upstream AXI-Stream.
REQ-016 SHALL have ports m_tdata/m_tvalid/m_tready  out/out/in  DWIDTH/1/1: downstream AXI-Stream.
REQ-017 SHALL have port beat_err_cnt  output  CNT_W: count of beats whose applied mask was nonzero.

Function
REQ-018 SHALL implement states IDLE, INJECT, GAP; "accepted beat" = s_tvalid & s_tready.
REQ-019 SHALL latch mode, threshold, burst_len, gap_len on start in IDLE; ignore start when busy or when mode=3.
REQ-020 SHALL treat latched burst_len=0 as 1; gap_len=0 SHALL skip GAP (INJECT->INJECT restarts the window).
REQ-021 CONT: IDLE->INJECT on start; stays in INJECT until stop.
REQ-022 BURST: INJECT->GAP after burst_len accepted beats, GAP->INJECT after gap_len accepted beats, repeats until stop.
REQ-023 SHALL, in SINGLE mode, transition INJECT->IDLE after burst_len accepted beats.
REQ-024 SHALL return to IDLE on the cycle after stop from any state; stop SHALL win over a same-cycle start.
REQ-025 SHALL still process a beat accepted in the stop cycle per the pre-stop state.
REQ-026 SHALL register threshold = latched threshold while busy, 0 in IDLE (one-cycle update).
REQ-027 SHALL form the datapath as one register stage: m_tdata <= s_tdata ^ (state==INJECT ? err_vec : 0) on accepted beats.
REQ-028 SHALL drive s_tready = !m_tvalid | m_tready; set m_tvalid on accept; clear it on m_tready without a new accept.
REQ-029 SHALL hold m_tdata/m_tvalid stable while m_tvalid & !m_tready; no beat lost or duplicated.
REQ-030 SHALL increment beat_err_cnt on accepted beats with a nonzero applied mask; saturate at all-ones; cnt_clr SHALL win over increment.
REQ-031 SHALL keep beat-window counters 16-bit; no wrap, since the window ends at equality.

Reset
REQ-032 SHALL, on rst, set state IDLE, busy 0, threshold 0, m_tvalid 0, m_tdata 0, beat_err_cnt 0, window counters 0, latched config 0.
REQ-033 SHALL apply rst mid-campaign identically; an in-flight output beat SHALL be dropped.

Configuration
REQ-034 SHALL provide macro RIFL_ERR_INJ_BITCNT_EN: when defined, add output bit_err_cnt (CNT_W) accumulating popcount of the applied mask per accepted beat (saturating, cleared by cnt_clr/rst).
REQ-035 SHALL omit bit_err_cnt port and popcount logic without the macro; all other behaviour is unchanged.

Structure
REQ-036 SHALL place the state enum and mode enum (CONT/BURST/SINGLE/RSVD) in package rifl_err_inj_pkg.
REQ-037 SHALL implement popcount as sub-module rifl_popcount (DWIDTH in, clog2(DWIDTH+1) out), instantiated only under the macro.

Verification
REQ-038 Reset: assert rst with m_tvalid=1 -> next cycle m_tvalid=0, busy=0, threshold=0, beat_err_cnt=0.
REQ-039 CONT: err_vec=all-ones, start, 5 beats of 0x0 -> m_tdata=all-ones x5, beat_err_cnt=5; stop -> busy=0 next cycle.
REQ-040 BURST: burst_len=2, gap_len=3, err_vec=0x1, 10 beats of 0 -> outputs 1,1,0,0,0,1,1,0,0,0; beat_err_cnt=4.
REQ-041 SINGLE: burst_len=0 -> exactly 1 corrupted beat, then busy=0; second start in same campaign ignored.
REQ-042 Backpressure: m_tready=0 for 4 cycles mid-burst -> m_tdata held, s_tready=0, window count frozen, no beat lost.
REQ-043 Macro on: err_vec=0xF, 3 injected beats -> bit_err_cnt=12; cnt_clr with a same-cycle hit -> counters 0.
